fetch_pair: RTL and testbench



---
 rtl/fetch_pair.sv | 148 ++++++++++++++
 tb/tb_fetch_pair.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pair.sv
// Dual-issue fetch stage: byte-loaded little-endian instruction memory,
// one (pc, pc+4) instruction pair per unstalled cycle until a zero word.
module fetch_pair #(
    parameter int IMEM_BYTES = 1024,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              start_i,
    input  logic              stall_i,
    output logic [31:0]       instr_1,
    output logic [31:0]       instr_2,
    output logic              en_flag_o,
    output logic [31:0]       c_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              done_o
);

    localparam int LP_IW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    // Two spare bits so pc can reach IMEM_BYTES (+4) and pc+7 without wrapping.
    localparam int LP_PW = ADDR_W + 2;
    localparam logic [LP_PW-1:0] LP_LIM = LP_PW'(IMEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_mem [IMEM_BYTES];
    logic [LP_PW-1:0]  r_pc, w_pc_nxt;
    logic [31:0]       r_i1, w_i1_nxt;
    logic [31:0]       r_i2, w_i2_nxt;
    logic [31:0]       r_c, w_c_nxt;
    logic [ADDR_W-1:0] r_pc_o, w_pc_o_nxt;
    logic              r_en, w_en_nxt;
    logic              r_done, w_done_nxt;
    logic [31:0]       w_word0, w_word1;
    logic              w_blocked;
    logic              w_ld_ok;

    function automatic logic [31:0] rd_word(input logic [LP_PW-1:0] a);
        logic [31:0]      w;
        logic [LP_PW-1:0] b;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            b = a + LP_PW'(k);
            if (b < LP_LIM) w[8*k +: 8] = r_mem[b[LP_IW-1:0]];
        end
        return w;
    endfunction

    assign w_word0   = rd_word(r_pc);
    assign w_word1   = rd_word(r_pc + LP_PW'(4));
    assign w_blocked = stall_i && r_en;
    assign w_ld_ok   = {2'b00, load_addr} < LP_LIM;

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && load_we && w_ld_ok)
            r_mem[load_addr[LP_IW-1:0]] <= load_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_i1_nxt    = r_i1;
        w_i2_nxt    = r_i2;
        w_c_nxt     = r_c;
        w_pc_o_nxt  = r_pc_o;
        w_en_nxt    = r_en;
        w_done_nxt  = r_done;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = '0;
                    w_i1_nxt    = '0;
                    w_i2_nxt    = '0;
                    w_c_nxt     = '0;
                    w_pc_o_nxt  = '0;
                    w_en_nxt    = 1'b0;
                    w_done_nxt  = 1'b0;
                end else if (r_state == S_DONE && !w_blocked) begin
                    w_en_nxt = 1'b0;
                    w_i1_nxt = '0;
                    w_i2_nxt = '0;
                end
            end
            S_RUN: begin
                w_c_nxt = r_c + 32'd1;
                if (!w_blocked) begin
                    if (r_pc >= LP_LIM || w_word0 == '0) begin
                        w_en_nxt    = 1'b0;
                        w_i1_nxt    = '0;
                        w_i2_nxt    = '0;
                        w_state_nxt = S_DONE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_i1_nxt   = w_word0;
                        w_i2_nxt   = w_word1;
                        w_pc_o_nxt = r_pc[ADDR_W-1:0];
                        w_en_nxt   = 1'b1;
                        w_pc_nxt   = r_pc + LP_PW'(8);
                        if (w_word1 == '0) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_i1    <= '0;
            r_i2    <= '0;
            r_c     <= '0;
            r_pc_o  <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_i1    <= w_i1_nxt;
            r_i2    <= w_i2_nxt;
            r_c     <= w_c_nxt;
            r_pc_o  <= w_pc_o_nxt;
            r_en    <= w_en_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign instr_1   = r_i1;
    assign instr_2   = r_i2;
    assign en_flag_o = r_en;
    assign c_o       = r_c;
    assign pc_o      = r_pc_o;
    assign done_o    = r_done;

endmodule

// File: tb/tb_fetch_pair.sv
// Scoreboard bench for fetch_pair: a default 1 KiB instance and a
// 16-byte instance share control inputs; one is observed at a time.
module tb_fetch_pair;

    typedef struct packed {
        logic [31:0] i1;
        logic [31:0] i2;
        logic [9:0]  pc;
        logic [31:0] c;
    } pair_t;

    logic        clk = 1'b0;
    logic        rst, start_i, stall_i, we_b, we_s, sel;
    logic [9:0]  ld_addr;
    logic [7:0]  ld_data;
    logic [31:0] b_i1, b_i2, b_c, s_i1, s_i2, s_c;
    logic [9:0]  b_pc;
    logic [3:0]  s_pc;
    logic        b_en, b_done, s_en, s_done;
    logic [31:0] m_i1, m_i2, m_c;
    logic [9:0]  m_pc;
    logic        m_en, m_done;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  img [0:1023];
    int          lim;
    logic [31:0] prog [0:15];
    pair_t       sb[$];
    int          exp_final;
    bit          hit;

    always #5 clk = ~clk;

    fetch_pair u_dut (
        .clk(clk), .rst(rst), .load_we(we_b), .load_addr(ld_addr),
        .load_data(ld_data), .start_i(start_i), .stall_i(stall_i),
        .instr_1(b_i1), .instr_2(b_i2), .en_flag_o(b_en), .c_o(b_c),
        .pc_o(b_pc), .done_o(b_done)
    );

    fetch_pair #(.IMEM_BYTES(16), .ADDR_W(4)) u_small (
        .clk(clk), .rst(rst), .load_we(we_s), .load_addr(ld_addr[3:0]),
        .load_data(ld_data), .start_i(start_i), .stall_i(stall_i),
        .instr_1(s_i1), .instr_2(s_i2), .en_flag_o(s_en), .c_o(s_c),
        .pc_o(s_pc), .done_o(s_done)
    );

    assign m_i1   = sel ? s_i1 : b_i1;
    assign m_i2   = sel ? s_i2 : b_i2;
    assign m_c    = sel ? s_c : b_c;
    assign m_pc   = sel ? {6'd0, s_pc} : b_pc;
    assign m_en   = sel ? s_en : b_en;
    assign m_done = sel ? s_done : b_done;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mword(input int a);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++)
            if (a + k < lim) w[8*k +: 8] = img[a+k];
        return w;
    endfunction

    task automatic load_byte(input int a, input logic [7:0] d);
        ld_addr = a[9:0];
        ld_data = d;
        we_b = !sel;
        we_s = sel;
        tick;
        we_b = 1'b0;
        we_s = 1'b0;
        img[a] = d;
    endtask

    task automatic load_prog(input int n, input bit pad);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int k = 0; k < 4; k++) load_byte(4*i + k, w[8*k +: 8]);
        end
        if (pad)
            for (int j = 0; j < 8; j++) load_byte(4*n + j, 8'h00);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    // Reference model: walk the image pair by pair from pc 0.
    task automatic build(input int stall_at, input int stall_len);
        pair_t it;
        int    pc, c, k;
        bit    last;
        sb.delete();
        pc = 0;
        c = 1;
        k = 0;
        last = 1'b0;
        while (!last && pc < lim && mword(pc) != 0) begin
            it.i1 = mword(pc);
            it.i2 = mword(pc + 4);
            it.pc = pc[9:0];
            it.c  = c;
            sb.push_back(it);
            if (k == stall_at) c += stall_len;
            c++;
            k++;
            if (it.i2 == 0) last = 1'b1;
            pc += 8;
        end
        exp_final = last ? c - 1 : c;
    endtask

    task automatic run(input int stall_at, input int stall_len,
                       input bit poke, input bit rst_at5, output bit hit5);
        pair_t last, it;
        int    sc, seen;
        bit    blocked, ended;
        hit5 = 1'b0;
        start_i = 1'b1;
        tick;
        start_i = 1'b0;
        we_b = 1'b0;
        we_s = 1'b0;
        stall_i = 1'b1;
        ended = 1'b0;
        sc = 0;
        seen = 0;
        last = '0;
        for (int cyc = 0; cyc < 80 && !ended && !hit5; cyc++) begin
            blocked = stall_i && m_en;
            if (poke && cyc == 1) begin
                ld_addr = '0;
                ld_data = 8'hFF;
                we_b = !sel;
                we_s = sel;
            end
            tick;
            we_b = 1'b0;
            we_s = 1'b0;
            if (blocked) begin
                sc++;
                check("hold_i1", m_i1, last.i1);
                check("hold_i2", m_i2, last.i2);
                check("hold_pc", {22'd0, m_pc}, {22'd0, last.pc});
                check("hold_c", m_c, last.c + sc);
            end else if (m_en) begin
                if (sb.size() == 0) begin
                    check("sb_extra", {31'd0, m_en}, 32'd0);
                end else begin
                    it = sb.pop_front();
                    check("pair_i1", m_i1, it.i1);
                    check("pair_i2", m_i2, it.i2);
                    check("pair_pc", {22'd0, m_pc}, {22'd0, it.pc});
                    check("pair_c", m_c, it.c);
                    if (it.i2 == 0) check("done_last", {31'd0, m_done}, 32'd1);
                    last = it;
                end
                seen++;
                sc = 0;
            end else if (m_done) begin
                ended = 1'b1;
            end
            if (rst_at5 && m_c == 32'd5) hit5 = 1'b1;
            stall_i = m_en && (seen - 1 == stall_at) && (sc < stall_len);
        end
        stall_i = 1'b0;
        if (!hit5) begin
            if (!ended) check("timeout", 32'd0, 32'd1);
            check("c_final", m_c, exp_final);
            check("done_end", {31'd0, m_done}, 32'd1);
            check("en_end", {31'd0, m_en}, 32'd0);
            check("sb_empty", sb.size(), 32'd0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_i1"}, m_i1, 32'd0);
        check({tag, "_i2"}, m_i2, 32'd0);
        check({tag, "_en"}, {31'd0, m_en}, 32'd0);
        check({tag, "_c"}, m_c, 32'd0);
        check({tag, "_pc"}, {22'd0, m_pc}, 32'd0);
        check({tag, "_done"}, {31'd0, m_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        stall_i = 1'b0;
        we_b = 1'b0;
        we_s = 1'b0;
        sel = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        lim = 1024;
        for (int i = 0; i < 1024; i++) img[i] = 8'h00;
        tick;
        tick;
        check_zero("reset");
        rst = 1'b0;

        prog[0] = 32'h00000013;
        prog[1] = 32'h00100093;
        prog[2] = 32'h00208133;
        prog[3] = 32'h402081B3;
        load_prog(4, 1'b1);
        build(-1, 0);
        run(-1, 0, 1'b0, 1'b0, hit);

        do_reset;
        prog[0] = 32'h11111111;
        prog[1] = 32'h22222222;
        prog[2] = 32'h33333333;
        load_prog(3, 1'b1);
        build(-1, 0);
        run(-1, 0, 1'b0, 1'b0, hit);

        do_reset;
        for (int i = 0; i < 6; i++) prog[i] = 32'hA0000001 + 32'(i * 16);
        load_prog(6, 1'b1);
        build(1, 3);
        run(1, 3, 1'b1, 1'b0, hit);
        build(-1, 0);
        run(-1, 0, 1'b0, 1'b0, hit);

        do_reset;
        for (int i = 0; i < 12; i++) prog[i] = 32'hC0DE0000 + 32'(i + 1);
        load_prog(12, 1'b1);
        build(-1, 0);
        run(-1, 0, 1'b0, 1'b1, hit);
        check("rst_at_c5", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_zero("midrun_rst");
        load_byte(0, 8'h93);
        load_byte(1, 8'h02);
        load_byte(2, 8'h50);
        ld_addr = 10'd3;
        ld_data = 8'h12;
        we_b = 1'b1;
        img[3] = 8'h12;
        build(-1, 0);
        run(-1, 0, 1'b0, 1'b0, hit);

        do_reset;
        sel = 1'b1;
        lim = 16;
        prog[0] = 32'h01010101;
        prog[1] = 32'h02020202;
        prog[2] = 32'h03030303;
        prog[3] = 32'h04040404;
        load_prog(4, 1'b0);
        build(-1, 0);
        run(-1, 0, 1'b0, 1'b0, hit);
        check("small_c", m_c, 32'd3);
        sel = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
